// File: rtl/decoder_5_32_seq_if.sv
// Request/response bundle for the sequential 5-to-32 decoder.
// The slave modport is the decoder's view; master is the requester/consumer side.
interface decoder_5_32_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  code;
  logic        sweep;
  logic [31:0] out;
  logic [4:0]  out_index;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (
    output in_valid, code, sweep, out_ready,
    input  in_ready, out, out_index, out_valid, out_last
  );

  modport slave (
    input  in_valid, code, sweep, out_ready,
    output in_ready, out, out_index, out_valid, out_last
  );
endinterface

// File: rtl/decoder_5_32_seq.sv
// Sequential 5-to-32 decoder: a request emits either one one-hot beat or a sweep
// of SWEEP_BEATS beats starting at the latched code, over a valid/ready handshake.
module decoder_5_32_seq #(
  parameter int SWEEP_BEATS = 32
) (
  input  logic              clock,
  input  logic              clear,
  decoder_5_32_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SINGLE, SWEEP} state_t;

  localparam logic [4:0] LAST_BEAT = 5'(SWEEP_BEATS - 1);

  state_t     state_q, state_d;
  logic [4:0] code_q, code_d;
  logic [4:0] beat_q, beat_d;

  logic       busy;
  logic       lastBeat;
  logic [4:0] beatIndex;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      code_q  <= 5'd0;
      beat_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      beat_q  <= beat_d;
    end
  end

  // Outputs depend only on registered state, so request inputs never reach out combinationally.
  assign busy      = (state_q != IDLE);
  assign lastBeat  = (state_q == SINGLE) || ((state_q == SWEEP) && (beat_q == LAST_BEAT));
  assign beatIndex = code_q + beat_q;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          code_d  = bus.code;
          beat_d  = 5'd0;
          state_d = bus.sweep ? SWEEP : SINGLE;
        end
      end
      SINGLE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      SWEEP: begin
        if (bus.out_ready) begin
          if (lastBeat) begin
            state_d = IDLE;
            beat_d  = 5'd0;
          end else begin
            beat_d  = beat_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = 5'd0;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = busy;
  assign bus.out_index = busy ? beatIndex : 5'd0;
  assign bus.out       = busy ? (32'd1 << beatIndex) : 32'h0;
  assign bus.out_last  = busy && lastBeat;

endmodule

// File: doc/decoder_5_32_seq.md
DECODER_5_32_SEQ -- requirements
Module: decoder_5_32_seq

Interface
REQ-001 The block SHALL have parameter SWEEP_BEATS, default 32, giving the number of one-hot beats emitted per sweep request (legal range 1..32).
REQ-002 The block SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port clear  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid  input  1  request present.
REQ-005 The block SHALL have port in_ready  output  1  block can accept a request.
REQ-006 The block SHALL have port code  input  5  binary register index to decode; sampled on accept.
REQ-007 The block SHALL have port sweep  input  1  request mode, sampled on accept: 0 = single beat, 1 = sweep of SWEEP_BEATS beats.
REQ-008 The block SHALL have port out  output  32  one-hot decoded select.
REQ-009 The block SHALL have port out_index  output  5  binary index of the asserted out bit.
REQ-010 The block SHALL have port out_valid  output  1  out/out_index valid.
REQ-011 The block SHALL have port out_ready  input  1  consumer accepts current beat.
REQ-012 The block SHALL have port out_last  output  1  current beat is final beat of the request.

Function
REQ-013 The state machine SHALL have states IDLE, SINGLE, SWEEP.
REQ-014 in_ready SHALL equal 1 exactly when state is IDLE.
REQ-015 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; code and sweep are latched.
REQ-016 On accept with sweep=0, the next state SHALL be SINGLE; with sweep=1, it SHALL be SWEEP, with beat counter = 0.
REQ-017 out_valid SHALL be 1 from the cycle after accept until the final beat handshake; there SHALL be no combinational path from in_valid or code to out.
REQ-018 A beat handshake SHALL occur on a rising edge with out_valid=1 and out_ready=1; out, out_index and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 When out_valid=1, out SHALL equal 1 << out_index, exactly one bit set; when out_valid=0, out SHALL be 32'h0, out_index 5'd0 and out_last 0.
REQ-020 In SINGLE, out_index SHALL equal the latched code and out_last=1; the handshake SHALL return the block to IDLE.
REQ-021 In SWEEP, beat n (0-based) SHALL have out_index = (latched code + n) mod 32, i.e. wrapping 31 -> 0.
REQ-022 In SWEEP, out_last SHALL be 1 exactly on beat SWEEP_BEATS-1; its handshake SHALL return the block to IDLE, and every other handshake advances n by one.
REQ-023 in_ready SHALL rise the cycle after the final handshake; there SHALL be no same-cycle accept-on-completion, giving a minimum of 2 cycles per single request.
REQ-024 in_valid while not IDLE SHALL be ignored, with no state change and no latching.
REQ-025 With SWEEP_BEATS=1, a sweep SHALL behave identically to a single request.

Reset
REQ-026 When clear=1 at a rising edge, the next state SHALL be IDLE regardless of in_valid or out_ready, and any in-progress request is discarded.
REQ-027 After clear, outputs SHALL be: in_ready=1, out_valid=0, out=32'h0, out_index=0, out_last=0, and beat counter=0.
REQ-028 clear SHALL take priority over a simultaneous accept or handshake.

Verification
REQ-029 Single, no backpressure: code=5'd13, sweep=0, out_ready=1 -> next cycle out=32'h0000_2000, out_index=13, out_last=1; in_ready=1 one cycle later.
REQ-030 Backpressure: code=5'd31, sweep=0, out_ready=0 for 4 cycles then 1 -> out=32'h8000_0000 held stable for 5 cycles, then out=0.
REQ-031 Sweep wrap: code=5'd30, sweep=1, SWEEP_BEATS=32, out_ready=1 -> out_index sequence 30,31,0,1,...,29; out_last only on index 29; 32 beats total.
REQ-032 Ignore while busy: during a sweep, pulse in_valid with code=5'd3 -> sequence unchanged, and code 3 is never emitted out of order.
REQ-033 Reset mid-sweep: assert clear on beat 5 -> next cycle out_valid=0, out=0, in_ready=1; a new request with code=5'd0, sweep=0 yields out=32'h0000_0001.
REQ-034 Exhaustive single: all 32 codes -> out has exactly one bit set at position code, and out_index=code.
